piccolo128_dec_iter: RTL

- Iterative Piccolo-128 decryption core: one round per clock, 31 rounds, with start/done handshake.
- Inverse counterpart of the team's Piccolo-128 encryption datapath; recovers 64-bit plaintext from ciphertext under a 128-bit key.
- Reuses the encryption round structure (F, RP). Round keys are generated on the fly in reverse order from an unwound key state, so no 62-entry key store is needed.

---
 rtl/piccolo128_dec_iter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/piccolo128_dec_iter.sv
// Iterative Piccolo-128 decryption core: one round per clock, 31 rounds.
// Round keys are produced in reverse order from an unwound key state, so
// no round-key store is kept.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   start          request, sampled only while idle
//   key_in         128-bit key K = k0..k7, k0 = key_in[0:15]
//   ciphertext_in  64-bit block to decrypt, bit 0 = MSB
//   plaintext_out  64-bit result, held until the next done
//   busy           high while rounds are running
//   done           one-cycle pulse when plaintext_out updates
module piccolo128_dec_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic [0:63]  ciphertext_in,
    output logic [0:63]  plaintext_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BLK_W    = 64;
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned NWORDS   = 8;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned LAST_RND = 30;
    localparam logic [31:0] CON_MASK = 32'h6547A98B;

    typedef logic [NWORDS-1:0][WORD_W-1:0] kstate_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    // 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'he;
            4'h1: y = 4'h4;
            4'h2: y = 4'hb;
            4'h3: y = 4'h2;
            4'h4: y = 4'h3;
            4'h5: y = 4'h8;
            4'h6: y = 4'h0;
            4'h7: y = 4'h9;
            4'h8: y = 4'h1;
            4'h9: y = 4'ha;
            4'ha: y = 4'h7;
            4'hb: y = 4'hf;
            4'hc: y = 4'h6;
            4'hd: y = 4'hc;
            4'he: y = 4'h5;
            default: y = 4'hd;
        endcase
        return y;
    endfunction

    // Multiply by x in GF(2^4) mod x^4+x+1
    function automatic logic [3:0] xt(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    // F: S-box layer, diffusion matrix, S-box layer
    function automatic logic [WORD_W-1:0] f_fn(input logic [WORD_W-1:0] x);
        logic [3:0] s0, s1, s2, s3;
        logic [3:0] m0, m1, m2, m3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        m0 = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
        m1 = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
        m2 = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
        m3 = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
        return {sbox(m0), sbox(m1), sbox(m2), sbox(m3)};
    endfunction

    // Byte permutation (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5), x0 = MSB
    function automatic logic [BLK_W-1:0] rp_fn(input logic [BLK_W-1:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48],
                x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    // Forward key-state permutation P
    function automatic kstate_t kp_fwd(input kstate_t k);
        kstate_t n;
        n[0] = k[2];
        n[1] = k[1];
        n[2] = k[6];
        n[3] = k[7];
        n[4] = k[0];
        n[5] = k[3];
        n[6] = k[4];
        n[7] = k[5];
        return n;
    endfunction

    // Inverse key-state permutation P^-1
    function automatic kstate_t kp_inv(input kstate_t k);
        kstate_t n;
        n[0] = k[4];
        n[1] = k[1];
        n[2] = k[0];
        n[3] = k[5];
        n[4] = k[6];
        n[5] = k[7];
        n[6] = k[2];
        n[7] = k[3];
        return n;
    endfunction

    // Key state as it stands for the final encryption round: P^7(K)
    function automatic kstate_t kp_seven(input kstate_t k);
        kstate_t n;
        n = k;
        for (int i = 0; i < 7; i++) begin
            n = kp_fwd(n);
        end
        return n;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    rnd;
    logic [BLK_W-1:0]    data_q;
    kstate_t             kst_q;
    logic [WORD_W-1:0]   wk0_q;
    logic [WORD_W-1:0]   wk1_q;

    logic [KEY_W-1:0]    key_flat;
    logic [BLK_W-1:0]    ct_flat;
    kstate_t             key_words;
    logic [WORD_W-1:0]   wk2, wk3;

    logic [CNT_W-1:0]    c_val;
    logic [31:0]         con_pair;
    logic [2:0]          idx_a, idx_b;
    logic [WORD_W-1:0]   key_a, key_b, rk_a, rk_b;
    logic [WORD_W-1:0]   x0, x1, x2, x3, nx1, nx3;
    logic [BLK_W-1:0]    rnd_out;

    assign key_flat = key_in;
    assign ct_flat  = ciphertext_in;

    // Split the key into k0..k7 (k0 is the most significant word)
    always_comb begin
        key_words = '0;
        for (int m = 0; m < NWORDS; m++) begin
            key_words[m] = key_flat[KEY_W-1-WORD_W*m -: WORD_W];
        end
    end

    // Input whitening words used at capture
    assign wk2 = {key_words[4][15:8], key_words[7][7:0]};
    assign wk3 = {key_words[7][15:8], key_words[4][7:0]};

    // One decryption round on the current data register
    always_comb begin
        // Round j uses constant pair 30-j, whose 5-bit counter value 31-j is ~j
        c_val    = ~rnd;
        con_pair = {c_val, 5'b0, c_val, 2'b00, c_val, 5'b0, c_val} ^ CON_MASK;
        // (62-2j) mod 8 = 2*(3-j mod 4)
        idx_a    = {~rnd[1:0], 1'b0};
        idx_b    = {~rnd[1:0], 1'b1};
        key_a    = kst_q[idx_a] ^ con_pair[31:16];
        key_b    = kst_q[idx_b] ^ con_pair[15:0];
        // Every RP swaps the halves' orientation, so odd rounds swap keys
        rk_a     = rnd[0] ? key_b : key_a;
        rk_b     = rnd[0] ? key_a : key_b;
        x0       = data_q[63:48];
        x1       = data_q[47:32];
        x2       = data_q[31:16];
        x3       = data_q[15:0];
        nx1      = x1 ^ f_fn(x0) ^ rk_a;
        nx3      = x3 ^ f_fn(x2) ^ rk_b;
        rnd_out  = {x0, nx1, x2, nx3};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            plaintext_out <= '0;
            rnd           <= '0;
            data_q        <= '0;
            kst_q         <= '0;
            wk0_q         <= '0;
            wk1_q         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_q <= {ct_flat[63:48] ^ wk2, ct_flat[47:32],
                                   ct_flat[31:16] ^ wk3, ct_flat[15:0]};
                        kst_q  <= kp_seven(key_words);
                        wk0_q  <= {key_words[0][15:8], key_words[1][7:0]};
                        wk1_q  <= {key_words[1][15:8], key_words[0][7:0]};
                        rnd    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rnd == CNT_W'(LAST_RND)) begin
                        plaintext_out <= {x0 ^ wk0_q, nx1, x2 ^ wk1_q, nx3};
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        data_q <= rp_fn(rnd_out);
                        rnd    <= rnd + CNT_W'(1);
                        // Step the key state back one schedule block every 4 rounds
                        if (rnd[1:0] == 2'b11) begin
                            kst_q <= kp_inv(kst_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
